food_manager: RTL
=================

Name: food_manager

Overview:
- Upstream producer of the score-increment request consumed by the seven-segment score display.
- Owns the food cell: places it pseudo-randomly on the playfield grid and detects when the snake head lands on it.
- On each eat event it raises add_cube as a clean level pulse (one display point per pulse), pulses grow to the snake body logic, and relocates the food.

Parameters:
- GRID_W, 40, playfield width in cells; legal x is 0..GRID_W-1 (max 64).
- GRID_H, 30, playfield height in cells; legal y is 0..GRID_H-1 (max 32).
- ADD_HOLD, 4, cycles add_cube stays high per eat event (min 1).
- MAX_TRIES, 64, placement attempts before the deterministic fallback.
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low; clock clk.
- game_en  in  1  high while a game is running.
- head_valid  in  1  one-cycle strobe: snake head has moved to (head_x, head_y).
- head_x  in  6  head column.
- head_y  in  5  head row.
- food_x  out  6  food column.
- food_y  out  5  food row.
- food_valid  out  1  food coordinates are valid and displayable.
- add_cube  out  1  score request level to the score display.
- grow  out  1  one-cycle pulse to the snake length logic.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, food_x=0, food_y=0, food_valid=0, add_cube=0, grow=0.
  - hold_cnt=0, try_cnt=0, lfsr=LFSR_SEED.
  - Takes effect at that edge regardless of current state or an in-progress hold.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every non-reset cycle in all states.
  - Candidate: cx=lfsr[5:0], cy=lfsr[12:8].
- States IDLE, PLACE, ACTIVE:
  - IDLE: food_valid=0. On game_en==1 go to PLACE with try_cnt=0.
  - PLACE: each cycle evaluate one candidate.
    - Accept if cx<GRID_W, cy<GRID_H, and !(cx==head_x && cy==head_y), using the current head inputs.
    - On accept: latch food_x/food_y; food_valid=1 on the same edge; go to ACTIVE.
    - On reject: try_cnt++.
    - When try_cnt==MAX_TRIES-1 and the candidate is rejected, use the fallback: (0,0) if the head is not there, else (GRID_W-1,GRID_H-1). Latch it and go to ACTIVE (placement latency ≤ MAX_TRIES cycles).
  - ACTIVE, eat event = head_valid && head_x==food_x && head_y==food_y. On the next edge:
    - food_valid=0, grow=1 for exactly one cycle.
    - add_cube=1, hold_cnt=ADD_HOLD-1.
    - try_cnt=0, state=PLACE.
  - head_valid without a match has no effect.
  - In IDLE and PLACE, head_valid is ignored; no eat is possible while food_valid=0.
- add_cube timing:
  - Driven by hold_cnt, independent of state.
  - High for exactly ADD_HOLD consecutive cycles, then low for at least 1 cycle before it can rise again.
  - If an eat occurs while add_cube is still high or in its mandatory low cycle, the request is queued (1-deep pending flag) and issued after the gap, so the downstream counter never misses a point.
- Game end:
  - game_en==0 in any state: next edge state=IDLE, food_valid=0, grow=0.
  - An in-flight add_cube hold completes normally; any pending request is discarded.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset hold 3 cycles, then release with game_en=0 -> all outputs 0, state IDLE, food_valid stays 0 for 20 cycles.
- Raise game_en, head=(5,5) -> food_valid=1 within 64 cycles; food_x<40, food_y<30, food≠(5,5); add_cube and grow stay 0.
- Food at (F), pulse head_valid with head=F at cycle N -> cycle N+1: grow=1 (one cycle), food_valid=0, add_cube=1 for cycles N+1..N+4, low at N+5; new food_valid within 64 cycles at a new legal cell.
- Override GRID_W=2, GRID_H=1, head=(0,0) -> placed food is exactly (1,0) (via random accept or fallback); never (0,0).
- Two eats 3 cycles apart (ADD_HOLD=4, second food forced adjacent) -> add_cube shows two distinct high pulses separated by ≥1 low cycle; downstream counter reads 2.
- Drop game_en mid-PLACE -> IDLE next edge, food_valid=0; assert reset during an add_cube hold -> add_cube=0 at that edge.

Source files
------------

// File: rtl/food_manager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : food_manager                                                     |
// | Brief   : Places food pseudo-randomly, detects eats, issues grow/add_cube. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module food_manager #(
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter int          ADD_HOLD  = 4,
  parameter int          MAX_TRIES = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_en,
  input  logic       head_valid,
  input  logic [5:0] head_x,
  input  logic [4:0] head_y,
  output logic [5:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       add_cube,
  output logic       grow
);

  localparam int c_try_w  = $clog2(MAX_TRIES + 1);
  localparam int c_hold_w = $clog2(ADD_HOLD + 1);

  localparam logic [c_try_w-1:0]  c_try_last  = c_try_w'(MAX_TRIES - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(ADD_HOLD - 1);
  localparam logic [6:0]          c_grid_w    = 7'(GRID_W);
  localparam logic [5:0]          c_grid_h    = 6'(GRID_H);
  localparam logic [5:0]          c_fall_x    = 6'(GRID_W - 1);
  localparam logic [4:0]          c_fall_y    = 5'(GRID_H - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_place  = 2'd1;
  localparam logic [1:0] c_st_active = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [15:0]         r_lfsr;
  logic                w_lfsr_fb;
  logic [5:0]          w_cx;
  logic [4:0]          w_cy;
  logic                w_cand_ok;
  logic                w_head_at_origin;
  logic                w_eat;
  logic [c_try_w-1:0]  r_try_cnt;
  logic [c_try_w-1:0]  w_try_nxt;
  logic [5:0]          w_food_x_nxt;
  logic [4:0]          w_food_y_nxt;
  logic                w_food_valid_nxt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic                r_gap;
  logic                r_pending;

  assign w_lfsr_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cx             = r_lfsr[5:0];
  assign w_cy             = r_lfsr[12:8];
  assign w_cand_ok        = ({1'b0, w_cx} < c_grid_w) && ({1'b0, w_cy} < c_grid_h) &&
                            !((w_cx == head_x) && (w_cy == head_y));
  assign w_head_at_origin = (head_x == 6'd0) && (head_y == 5'd0);
  assign w_eat            = game_en && (r_state == c_st_active) && food_valid && head_valid &&
                            (head_x == food_x) && (head_y == food_y);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!game_en) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:   w_next_state = c_st_place;
        c_st_place:  if (w_cand_ok || (r_try_cnt == c_try_last)) w_next_state = c_st_active;
        c_st_active: if (w_eat) w_next_state = c_st_place;
        default:     w_next_state = c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_food_x_nxt     = food_x;
    w_food_y_nxt     = food_y;
    w_food_valid_nxt = food_valid;
    w_try_nxt        = r_try_cnt;
    if (!game_en) begin
      w_food_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_food_valid_nxt = 1'b0;
          w_try_nxt        = '0;
        end
        c_st_place: begin
          if (w_cand_ok) begin
            w_food_x_nxt     = w_cx;
            w_food_y_nxt     = w_cy;
            w_food_valid_nxt = 1'b1;
          end else if (r_try_cnt == c_try_last) begin
            // Fallback guarantees bounded placement latency.
            w_food_x_nxt     = w_head_at_origin ? c_fall_x : 6'd0;
            w_food_y_nxt     = w_head_at_origin ? c_fall_y : 5'd0;
            w_food_valid_nxt = 1'b1;
          end else begin
            w_try_nxt = r_try_cnt + c_try_w'(1);
          end
        end
        c_st_active: begin
          if (w_eat) begin
            w_food_valid_nxt = 1'b0;
            w_try_nxt        = '0;
          end
        end
        default: w_food_valid_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr     <= LFSR_SEED;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      grow       <= 1'b0;
      r_try_cnt  <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
      food_x     <= w_food_x_nxt;
      food_y     <= w_food_y_nxt;
      food_valid <= w_food_valid_nxt;
      grow       <= w_eat;
      r_try_cnt  <= w_try_nxt;
    end
  end

  // Score request: ADD_HOLD high cycles, one mandatory low cycle, 1-deep pending queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      add_cube   <= 1'b0;
      r_hold_cnt <= '0;
      r_gap      <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (add_cube) begin
        if (r_hold_cnt == '0) begin
          add_cube <= 1'b0;
          r_gap    <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt - c_hold_w'(1);
        end
        if (w_eat) r_pending <= 1'b1;
      end else if (r_gap) begin
        r_gap     <= 1'b0;
        r_pending <= 1'b0;
        if (w_eat || (r_pending && game_en)) begin
          add_cube   <= 1'b1;
          r_hold_cnt <= c_hold_last;
        end
      end else if (w_eat) begin
        add_cube   <= 1'b1;
        r_hold_cnt <= c_hold_last;
      end
      if (!game_en) r_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire
